// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and stage-control payload for the pipeline stall controller.
package pipe_ctrl_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned CTRL_W  = 8;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_RUN      = 2'd0;
   localparam state_t ST_MEM_WAIT = 2'd1;
   localparam state_t ST_MDU_WAIT = 2'd2;
   localparam state_t ST_ERR      = 2'd3;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic ex_mem_write;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_bubble;
      logic mem_wb_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN = ctrl_t'(8'b1111_0000);
   localparam ctrl_t CTRL_OFF = ctrl_t'(8'b0000_0000);

   // Priority resolution: memory miss > MDU busy > load-use > branch.
   function automatic ctrl_t resolve(input logic mem_miss, input logic mdu_busy,
                                     input logic load_use, input logic branch);
      ctrl_t c;
      c = CTRL_RUN;
      if (mem_miss) begin
         c.pc_write      = 1'b0;
         c.if_id_write   = 1'b0;
         c.id_ex_write   = 1'b0;
         c.ex_mem_write  = 1'b0;
         c.mem_wb_bubble = 1'b1;
      end else if (mdu_busy) begin
         c.pc_write      = 1'b0;
         c.if_id_write   = 1'b0;
         c.id_ex_write   = 1'b0;
         c.ex_mem_bubble = 1'b1;
      end else if (load_use) begin
         c.pc_write      = 1'b0;
         c.if_id_write   = 1'b0;
         c.id_ex_flush   = 1'b1;
      end else if (branch) begin
         c.if_id_flush   = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/stall_timer.sv
// Wait-state timer: cleared on entry to a wait, counts wait cycles, flags the last one.
module stall_timer #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // Flag the cycle whose increment makes the count reach TIMEOUT.
   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + TO_W'(1);
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller with wait-state timeout.
// Optional stall-cycle counter on StallCnt_o is built when STALL_CNT_EN is defined.
module pipeline_stall_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        LoadUse_i,
   input  logic        Branch_i,
   input  logic        MemReq_i,
   input  logic        MemAck_i,
   input  logic        MduStart_i,
   input  logic        MduDone_i,
   output logic        PCWrite_o,
   output logic        IF_ID_Write_o,
   output logic        ID_EX_Write_o,
   output logic        EX_MEM_Write_o,
   output logic        IF_ID_Flush_o,
   output logic        ID_EX_Flush_o,
   output logic        EX_MEM_Bubble_o,
   output logic        MEM_WB_Bubble_o,
   output logic        Err_o,
   output logic [31:0] StallCnt_o
);

   state_t state, state_nxt;
   ctrl_t  ctrl;
   logic   err;
   logic   tmr_clr, tmr_en, tmr_expired;
   logic   mem_miss, mdu_busy;

   assign mem_miss = MemReq_i & ~MemAck_i;
   assign mdu_busy = MduStart_i & ~MduDone_i;

   stall_timer #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timer (
      .clk     (clk_i),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   // Next state, stage controls and timer control.
   always_comb begin
      state_nxt = state;
      ctrl      = CTRL_OFF;
      err       = 1'b0;
      tmr_clr   = 1'b1;
      tmr_en    = 1'b0;
      case (state)
         ST_RUN: begin
            ctrl = resolve(mem_miss, mdu_busy, LoadUse_i, Branch_i);
            if (mem_miss)
               state_nxt = ST_MEM_WAIT;
            else if (mdu_busy)
               state_nxt = ST_MDU_WAIT;
         end
         ST_MEM_WAIT: begin
            if (!MemAck_i) begin
               ctrl      = resolve(1'b1, 1'b0, 1'b0, 1'b0);
               tmr_clr   = 1'b0;
               tmr_en    = 1'b1;
               state_nxt = tmr_expired ? ST_ERR : ST_MEM_WAIT;
            end else begin
               ctrl      = resolve(1'b0, mdu_busy, LoadUse_i, Branch_i);
               state_nxt = mdu_busy ? ST_MDU_WAIT : ST_RUN;
            end
         end
         ST_MDU_WAIT: begin
            // MEM holds a bubble while the MDU is busy, so MemReq_i is ignored.
            if (!MduDone_i) begin
               ctrl      = resolve(1'b0, 1'b1, 1'b0, 1'b0);
               tmr_clr   = 1'b0;
               tmr_en    = 1'b1;
               state_nxt = tmr_expired ? ST_ERR : ST_MDU_WAIT;
            end else begin
               ctrl      = resolve(mem_miss, 1'b0, LoadUse_i, Branch_i);
               state_nxt = ST_RUN;
            end
         end
         default: begin
            // ST_ERR: frozen until reset
            err = 1'b1;
         end
      endcase
      if (rst_i) begin
         state_nxt = ST_RUN;
         ctrl      = CTRL_OFF;
         err       = 1'b0;
         tmr_clr   = 1'b1;
         tmr_en    = 1'b0;
      end
   end

   assign PCWrite_o       = ctrl.pc_write;
   assign IF_ID_Write_o   = ctrl.if_id_write;
   assign ID_EX_Write_o   = ctrl.id_ex_write;
   assign EX_MEM_Write_o  = ctrl.ex_mem_write;
   assign IF_ID_Flush_o   = ctrl.if_id_flush;
   assign ID_EX_Flush_o   = ctrl.id_ex_flush;
   assign EX_MEM_Bubble_o = ctrl.ex_mem_bubble;
   assign MEM_WB_Bubble_o = ctrl.mem_wb_bubble;
   assign Err_o           = err;

`ifdef STALL_CNT_EN
   logic [31:0] stall_cnt;

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         stall_cnt <= '0;
      else if (!ctrl.pc_write && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign StallCnt_o = stall_cnt;
`else
   assign StallCnt_o = '0;
`endif

endmodule
